rpn_eval: RTL and testbench

Reverse-Polish expression evaluator that sits directly upstream of the `stack` block and is its only producer and consumer. It accepts a token stream (operands and operators) over a valid/ready handshake, pushes operands onto the stack, and for each operator pops two entries, computes the result and pushes it back. It also reports each result and any stack overflow or underflow as a sticky error.

---
 rtl/rpn_eval.sv | 133 +++++++++++++
 tb/tb_rpn_eval.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator: operands are pushed onto an external stack, and each operator pops two entries and pushes the result.
// Latency: an operand is pushed 1 cycle after acceptance; an operator result is pushed 5 cycles after acceptance. Takes one token per IDLE cycle.
// Backpressure: tok_ready is low outside IDLE, while err is set, and during clr.
module rpn_eval #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clr,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic                  tok_is_op,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  stk_push,
    output logic [DATA_WIDTH-1:0] stk_wr_data,
    input  logic                  stk_full,
    output logic                  stk_pop,
    input  logic [DATA_WIDTH-1:0] stk_rd_data,
    input  logic                  stk_empty
);

    typedef enum logic [2:0] {
        IDLE, PUSH_OPND, POP_B, WAIT_B, POP_A, WAIT_A, EXEC
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] opnd, b_reg, r_reg, alu;
    logic [1:0]            op;
    logic                  accept, set_ovf, set_unf;

    assign accept   = tok_valid & tok_ready;
    assign res_data = r_reg;

    // a is the entry below b, read from the stack in WAIT_A
    always_comb begin
        alu = '0;
        unique case (op)
            2'b00: alu = stk_rd_data + b_reg;
            2'b01: alu = stk_rd_data - b_reg;
            2'b10: alu = stk_rd_data & b_reg;
            2'b11: alu = stk_rd_data ^ b_reg;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        tok_ready   = (state == IDLE) & ~err & ~clr;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        res_valid   = 1'b0;
        stk_wr_data = '0;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) state_nxt = tok_is_op ? POP_B : PUSH_OPND;
                end
                PUSH_OPND: begin
                    state_nxt = IDLE;
                    if (stk_full) begin
                        set_ovf = 1'b1;
                    end else begin
                        stk_push    = arst_n;
                        stk_wr_data = opnd;
                    end
                end
                POP_B: begin
                    if (stk_empty) begin
                        set_unf   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stk_pop   = arst_n;
                        state_nxt = WAIT_B;
                    end
                end
                WAIT_B: state_nxt = POP_A;
                POP_A: begin
                    if (stk_empty) begin
                        set_unf   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        stk_pop   = arst_n;
                        state_nxt = WAIT_A;
                    end
                end
                WAIT_A: state_nxt = EXEC;
                EXEC: begin
                    stk_push    = arst_n;
                    stk_wr_data = r_reg;
                    res_valid   = arst_n;
                    state_nxt   = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state    <= IDLE;
            opnd     <= '0;
            op       <= 2'b00;
            b_reg    <= '0;
            r_reg    <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opnd <= tok_data;
                op   <= tok_data[1:0];
            end
            if (state == WAIT_B && !clr) b_reg <= stk_rd_data;
            if (state == WAIT_A && !clr) r_reg <= alu;
            // only the first error is kept until clr
            if (clr) begin
                err      <= 1'b0;
                err_code <= 2'b00;
            end else if (!err && (set_ovf || set_unf)) begin
                err      <= 1'b1;
                err_code <= set_ovf ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_rpn_eval.sv
// Directed bench for rpn_eval with a 16-entry behavioural stack attached.
module tb_rpn_eval;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          clr = 1'b0;
    logic          tok_valid = 1'b0;
    logic          tok_is_op = 1'b0;
    logic [DW-1:0] tok_data = '0;
    logic          tok_ready, res_valid, err, stk_push, stk_pop, stk_full, stk_empty;
    logic [DW-1:0] res_data, stk_wr_data, stk_rd_data;
    logic [1:0]    err_code;

    int checks = 0;
    int failures = 0;

    // behavioural stack
    logic [DW-1:0] mem [DEPTH];
    int            cnt = 0;
    int            push_total = 0;
    int            cyc = 0;
    int            acc_cyc [$];
    logic [DW-1:0] acc_dat [$];
    logic [DW-1:0] res_q [$];

    assign stk_full  = (cnt == DEPTH);
    assign stk_empty = (cnt == 0);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!arst_n) begin
            cnt         <= 0;
            stk_rd_data <= '0;
        end else begin
            if (stk_push) push_total <= push_total + 1;
            if (stk_push && cnt < DEPTH) begin
                mem[cnt] <= stk_wr_data;
                cnt      <= cnt + 1;
            end else if (stk_pop && cnt > 0) begin
                stk_rd_data <= mem[cnt-1];
                cnt         <= cnt - 1;
            end
            if (tok_valid && tok_ready) begin
                acc_cyc.push_back(cyc);
                acc_dat.push_back(tok_data);
            end
            if (res_valid) res_q.push_back(res_data);
        end
    end

    rpn_eval #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .arst_n(arst_n), .clr(clr),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
        .res_valid(res_valid), .res_data(res_data), .err(err), .err_code(err_code),
        .stk_push(stk_push), .stk_wr_data(stk_wr_data), .stk_full(stk_full),
        .stk_pop(stk_pop), .stk_rd_data(stk_rd_data), .stk_empty(stk_empty)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        tick(3);
        arst_n = 1'b1;
    endtask

    // Offers one token; returns #1 into the cycle after the acceptance edge (T+1).
    task automatic send(input logic is_op, input logic [DW-1:0] d);
        int budget;
        budget = 0;
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        while (!tok_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!tok_ready) chk("send_timeout", 32'd0, 32'd1);
        tick();
        tok_valid = 1'b0;
        tok_data  = '0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (!tok_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!tok_ready) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    logic [DW-1:0] toks [5];
    logic          top  [5];
    int            idx, budget, pushes0, nacc;
    logic          will_acc;

    initial begin
        // reset values
        tick();
        chk("rst_push_low", {31'd0, stk_push}, 32'd0);
        chk("rst_pop_low", {31'd0, stk_pop}, 32'd0);
        do_reset();
        chk("rst_tok_ready", {31'd0, tok_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_push", {31'd0, stk_push}, 32'd0);
        chk("rst_pop", {31'd0, stk_pop}, 32'd0);
        chk("rst_wr_data", stk_wr_data, 32'd0);

        // subtraction 5 3 SUB with cycle timing
        send(1'b0, 32'd5);
        chk("opnd_push_t1", {31'd0, stk_push}, 32'd1);
        chk("opnd_wr_data", stk_wr_data, 32'd5);
        chk("opnd_busy_t1", {31'd0, tok_ready}, 32'd0);
        tick();
        chk("opnd_ready_t2", {31'd0, tok_ready}, 32'd1);
        send(1'b0, 32'd3);
        tick();
        send(1'b1, 32'd1);
        chk("sub_pop_b_t1", {31'd0, stk_pop}, 32'd1);
        tick(3);
        chk("sub_no_res_t4", {31'd0, res_valid}, 32'd0);
        tick();
        chk("sub_res_valid_t5", {31'd0, res_valid}, 32'd1);
        chk("sub_push_t5", {31'd0, stk_push}, 32'd1);
        chk("sub_wr_data_t5", stk_wr_data, 32'd2);
        tick();
        chk("sub_ready_t6", {31'd0, tok_ready}, 32'd1);
        chk("sub_res_data", res_data, 32'd2);
        chk("sub_stack_cnt", cnt, 32'd1);
        chk("sub_stack_top", mem[0], 32'd2);

        // wrap-around
        send(1'b0, 32'hFFFF_FFFF);
        send(1'b0, 32'd1);
        send(1'b1, 32'd0);
        wait_idle();
        chk("wrap_res", res_data, 32'd0);
        chk("wrap_err", {31'd0, err}, 32'd0);

        // underflow and recovery
        do_reset();
        send(1'b0, 32'd7);
        wait_idle();
        pushes0 = push_total;
        send(1'b1, 32'd0);
        tick(3);
        chk("unf_err", {31'd0, err}, 32'd1);
        chk("unf_code", {30'd0, err_code}, 32'd2);
        tick(2);
        chk("unf_ready", {31'd0, tok_ready}, 32'd0);
        chk("unf_no_push", push_total, pushes0);
        clr = 1'b1;
        tok_valid = 1'b1;
        chk("clr_blocks_ready", {31'd0, tok_ready}, 32'd0);
        tick();
        clr = 1'b0;
        tok_valid = 1'b0;
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_code", {30'd0, err_code}, 32'd0);
        send(1'b0, 32'd4);
        send(1'b0, 32'd4);
        send(1'b1, 32'd3);
        wait_idle();
        chk("xor_res", res_data, 32'd0);

        // overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(1'b0, i + 100);
        tick();
        chk("ovf_cnt_full", cnt, DEPTH);
        pushes0 = push_total;
        send(1'b0, 32'd999);
        chk("ovf_no_push", {31'd0, stk_push}, 32'd0);
        tick();
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_code", {30'd0, err_code}, 32'd1);
        chk("ovf_push_total", push_total, pushes0);
        nacc = acc_cyc.size();
        tok_valid = 1'b1;
        tok_data  = 32'd5;
        tick(4);
        tok_valid = 1'b0;
        chk("ovf_no_accept", acc_cyc.size(), nacc);
        chk("ovf_top_kept", mem[DEPTH-1], 32'd115);

        // reset during an operation
        do_reset();
        send(1'b0, 32'd1);
        send(1'b0, 32'd2);
        send(1'b1, 32'd0);
        tick(1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_no_pop", {31'd0, stk_pop}, 32'd0);
        tick();
        arst_n = 1'b1;
        chk("mid_rst_ready", {31'd0, tok_ready}, 32'd1);
        chk("mid_rst_push", {31'd0, stk_push}, 32'd0);

        // back-pressure: tok_valid held high throughout
        do_reset();
        acc_cyc.delete();
        acc_dat.delete();
        res_q.delete();
        toks = '{32'd3, 32'd6, 32'd2, 32'd7, 32'd3};
        top  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        budget = 0;
        tok_valid = 1'b1;
        while (idx < 5 && budget < 100) begin
            tok_is_op = top[idx];
            tok_data  = toks[idx];
            #1;
            will_acc = tok_ready;
            tick();
            if (will_acc) idx++;
            budget++;
        end
        tok_valid = 1'b0;
        if (idx < 5) chk("bp_timeout", idx, 32'd5);
        wait_idle();
        tick();
        chk("bp_accepts", acc_cyc.size(), 32'd5);
        if (acc_cyc.size() == 5) begin
            chk("bp_gap0", acc_cyc[1] - acc_cyc[0], 32'd2);
            chk("bp_gap1", acc_cyc[2] - acc_cyc[1], 32'd2);
            chk("bp_gap2", acc_cyc[3] - acc_cyc[2], 32'd6);
            chk("bp_gap3", acc_cyc[4] - acc_cyc[3], 32'd2);
            for (int i = 0; i < 5; i++) chk("bp_tok", acc_dat[i], toks[i]);
        end
        chk("bp_nres", res_q.size(), 32'd2);
        if (res_q.size() == 2) begin
            chk("bp_res0", res_q[0], 32'd2);
            chk("bp_res1", res_q[1], 32'd5);
        end
        chk("bp_stack_cnt", cnt, 32'd1);
        chk("bp_stack_top", mem[0], 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
